button_event_classifier: RTL and testbench
==========================================

// Module: button_event_classifier
// PURPOSE
//  Consumes the clean level from the button debouncer and classifies it into single-cycle event pulses.
//  Events: short press, double press, long press, auto-repeat while held.
//  Sits between the debouncer output and the UI/control FSMs, which act on pulses only.
// PARAMETERS
//  CLK_PERIOD_NS    10   clock period; MS_CYCLES = 1_000_000/CLK_PERIOD_NS (must be >=1)
//  LONG_PRESS_MS   500   hold time for long press (>=1)
//  DOUBLE_GAP_MS   250   max release gap for a second press to count as double (>=1)
//  REPEAT_MS       100   repeat period while held after long press; 0 = repeat disabled
// PORTS
//  clk_in            in   1  system clock
//  rst_n_in          in   1  synchronous reset, active low
//  btn_in            in   1  debounced button level, synchronous to clk_in, 1 = pressed
//  short_press_out   out  1  one-cycle pulse: single short press
//  double_press_out  out  1  one-cycle pulse: double press
//  long_press_out    out  1  one-cycle pulse: long-press threshold reached
//  repeat_out        out  1  one-cycle pulse: auto-repeat while held
//  state_out         out  3  current FSM state, debug (IDLE=0,PRESS1=1,GAP=2,PRESS2=3,HOLD=4)
// BEHAVIOUR
//  Reset (rst_n_in=0 at posedge)
//   - state=IDLE, prescaler=0, ms_cnt=0, all pulse outputs 0, state_out=0.
//   - btn_q (registered btn_in) is set to 1.
//   - A button held through reset is therefore not a press; its later fall in IDLE is ignored.
//  Edges: rise = btn_in & ~btn_q; fall = ~btn_in & btn_q. btn_q <= btn_in every cycle.
//  Prescaler: free-running 0..MS_CYCLES-1. ms_tick is high in the cycle it equals MS_CYCLES-1.
//  ms_cnt: cleared to 0 on every state transition; otherwise +1 on ms_tick; saturates at max.
//   - Width = $clog2(max(LONG_PRESS_MS,DOUBLE_GAP_MS,REPEAT_MS)+1).
//  "Expires(N)" = ms_tick && ms_cnt==N-1, evaluated on current-cycle values.
//  FSM (an edge always takes priority over expiry in the same cycle):
//   IDLE   : rise -> PRESS1. Fall ignored.
//   PRESS1 : fall -> GAP.
//            else Expires(LONG_PRESS_MS) -> HOLD and pulse long_press_out.
//   GAP    : rise -> PRESS2.
//            else Expires(DOUBLE_GAP_MS) -> IDLE and pulse short_press_out.
//   PRESS2 : fall -> IDLE and pulse double_press_out. No long/repeat from PRESS2, any duration.
//   HOLD   : fall -> IDLE, no pulse.
//            else if REPEAT_MS!=0 and Expires(REPEAT_MS): pulse repeat_out, clear ms_cnt, stay in HOLD.
//  Timing and pulse rules:
//   - Pulse outputs are registered; they are high exactly one cycle, the cycle after the deciding edge.
//   - At most one pulse output is high in any cycle.
//   - Latency: double_press_out is high 1 cycle after the cycle in which fall is seen.
//   - Reset mid-operation aborts any pending event with no pulse; pulse registers clear on that edge.
//   - Unknown or illegal state encodings recover to IDLE on the next clock.
// TESTING  (CLK_PERIOD_NS=1_000_000 -> ms_tick every cycle; LONG=8, GAP=4, REPEAT=3)
//  T1 Short press:
//     btn_in 1 for 3 cycles, then 0.
//     -> short_press_out 1 for one cycle, exactly 4 cycles after GAP entry; no other pulse.
//  T2 Double press:
//     btn_in 1x2, 0x2, 1x2, 0.
//     -> double_press_out pulse 1 cycle after the second fall; short_press_out never asserts.
//  T3 Long + repeat:
//     btn_in 1 for 19 cycles after PRESS1 entry, then 0.
//     -> long_press_out at +8; repeat_out at +11, +14, +17; no pulse on release.
//  T4 Boundary collisions (edge beats expiry):
//     (a) fall in the cycle where ms_cnt==7 in PRESS1 -> GAP, then short; long never fires.
//     (b) rise in the cycle where ms_cnt==3 in GAP -> PRESS2; short never fires.
//  T5 Reset mid-event:
//     Drive rst_n_in=0 for 1 cycle while in GAP -> no short pulse, state_out=0.
//     Keep btn_in=1 through reset release -> no event until a new release then press.
//  T6 REPEAT_MS=0:
//     hold 30 cycles -> single long_press_out at +8, zero repeat_out pulses.

Source files
------------

// File: rtl/button_event_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_event_classifier                                                  |
// | Turns a debounced button level into short/double/long/repeat pulses.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_event_classifier #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int LONG_PRESS_MS = 500,
    parameter int DOUBLE_GAP_MS = 250,
    parameter int REPEAT_MS     = 100
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       btn_in,
    output logic       short_press_out,
    output logic       double_press_out,
    output logic       long_press_out,
    output logic       repeat_out,
    output logic [2:0] state_out
);
    localparam int c_ms_cycles = 1_000_000 / CLK_PERIOD_NS;
    localparam int c_pre_w     = (c_ms_cycles > 1) ? $clog2(c_ms_cycles) : 1;
    localparam int c_max_lg    = (LONG_PRESS_MS > DOUBLE_GAP_MS) ? LONG_PRESS_MS : DOUBLE_GAP_MS;
    localparam int c_max_ms    = (c_max_lg > REPEAT_MS) ? c_max_lg : REPEAT_MS;
    localparam int c_cnt_w     = $clog2(c_max_ms + 1);

    localparam logic [c_pre_w-1:0] c_pre_last  = c_pre_w'(c_ms_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(LONG_PRESS_MS - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(DOUBLE_GAP_MS - 1);
    localparam logic [c_cnt_w-1:0] c_rep_last  = c_cnt_w'(REPEAT_MS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = {c_cnt_w{1'b1}};
    localparam bit                 c_rep_en    = (REPEAT_MS != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_GAP    = 3'd2,
        S_PRESS2 = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_btn_q;
    logic [c_pre_w-1:0]   r_pre;
    logic [c_cnt_w-1:0]   r_ms_cnt;
    logic                 r_short, r_double, r_long, r_repeat;

    logic w_rise, w_fall, w_tick, w_restart;
    logic w_short, w_double, w_long, w_repeat;

    assign w_rise = btn_in & ~r_btn_q;
    assign w_fall = ~btn_in & r_btn_q;
    assign w_tick = (r_pre == c_pre_last);

    // Edges are tested before expiry so a coincident edge always wins.
    always_comb begin
        w_next    = r_state;
        w_short   = 1'b0;
        w_double  = 1'b0;
        w_long    = 1'b0;
        w_repeat  = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_next = S_PRESS1;
            end
            S_PRESS1: begin
                if (w_fall) begin
                    w_next = S_GAP;
                end else if (w_tick && r_ms_cnt == c_long_last) begin
                    w_next = S_HOLD;
                    w_long = 1'b1;
                end
            end
            S_GAP: begin
                if (w_rise) begin
                    w_next = S_PRESS2;
                end else if (w_tick && r_ms_cnt == c_gap_last) begin
                    w_next  = S_IDLE;
                    w_short = 1'b1;
                end
            end
            S_PRESS2: begin
                if (w_fall) begin
                    w_next   = S_IDLE;
                    w_double = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_fall) begin
                    w_next = S_IDLE;
                end else if (c_rep_en && w_tick && r_ms_cnt == c_rep_last) begin
                    w_repeat  = 1'b1;
                    w_restart = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // btn_q resets high so a button held through reset never reads as a press.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state  <= S_IDLE;
            r_btn_q  <= 1'b1;
            r_pre    <= '0;
            r_ms_cnt <= '0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_btn_q  <= btn_in;
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            if (w_next != r_state || w_restart) begin
                r_ms_cnt <= '0;
            end else if (w_tick && r_ms_cnt != c_cnt_max) begin
                r_ms_cnt <= r_ms_cnt + 1'b1;
            end
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
        end
    end

    assign short_press_out  = r_short;
    assign double_press_out = r_double;
    assign long_press_out   = r_long;
    assign repeat_out       = r_repeat;
    assign state_out        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_button_event_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_event_classifier                                               |
// | Scoreboard bench: expected pulses queued at stimulus, popped on output.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_button_event_classifier;
    localparam int c_k_short  = 1;
    localparam int c_k_double = 2;
    localparam int c_k_long   = 3;
    localparam int c_k_repeat = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_a, btn_b;
    logic       sp_a, dp_a, lp_a, rp_a;
    logic       sp_b, dp_b, lp_b, rp_b;
    logic [2:0] st_a, st_b;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  k;
    ev_t q_a[$];
    ev_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_event_classifier #(
        .CLK_PERIOD_NS(1_000_000), .LONG_PRESS_MS(8), .DOUBLE_GAP_MS(4), .REPEAT_MS(3)
    ) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .btn_in(btn_a),
        .short_press_out(sp_a), .double_press_out(dp_a),
        .long_press_out(lp_a), .repeat_out(rp_a), .state_out(st_a)
    );

    button_event_classifier #(
        .CLK_PERIOD_NS(1_000_000), .LONG_PRESS_MS(8), .DOUBLE_GAP_MS(4), .REPEAT_MS(0)
    ) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .btn_in(btn_b),
        .short_press_out(sp_b), .double_press_out(dp_b),
        .long_press_out(lp_b), .repeat_out(rp_b), .state_out(st_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic expect_ev(input int which, input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        if (which == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic observe(input int which, input logic [3:0] w);
        ev_t   e;
        int    kind;
        int    qsz;
        string pfx;
        pfx = (which == 0) ? "A" : "B";
        if (w == 4'b0000) return;
        if ($countones(w) != 1) begin
            check({pfx, "_multi_pulse"}, $countones(w), 1);
            return;
        end
        kind = w[0] ? c_k_short : w[1] ? c_k_double : w[2] ? c_k_long : c_k_repeat;
        qsz  = (which == 0) ? q_a.size() : q_b.size();
        if (qsz == 0) begin
            check({pfx, "_unexpected_kind"}, kind, 0);
            return;
        end
        if (which == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        check({pfx, "_evt_kind"}, kind, e.kind);
        check({pfx, "_evt_cycle"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        observe(0, {rp_a, lp_a, dp_a, sp_a});
        observe(1, {rp_b, lp_b, dp_b, sp_b});
    end

    // Each value is sampled by the posedge following the call point.
    task automatic drive(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) btn_a = v;
            else btn_b = v;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state_a", int'(st_a), 0);
        check("rst_pulses_a", int'({rp_a, lp_a, dp_a, sp_a}), 0);
        check("rst_state_b", int'(st_b), 0);
        rst_n = 1'b1;
        drive(0, 1'b0, 3);
        check("idle_after_rst", int'(st_a), 0);

        // T1 short press
        k = cyc + 1;
        expect_ev(0, c_k_short, k + 7);
        drive(0, 1'b1, 3);
        check("t1_press1", int'(st_a), 1);
        drive(0, 1'b0, 1);
        check("t1_gap", int'(st_a), 2);
        drive(0, 1'b0, 9);
        check("t1_pending", q_a.size(), 0);

        // T2 double press
        k = cyc + 1;
        expect_ev(0, c_k_double, k + 6);
        drive(0, 1'b1, 2);
        drive(0, 1'b0, 2);
        drive(0, 1'b1, 1);
        check("t2_press2", int'(st_a), 3);
        drive(0, 1'b1, 1);
        drive(0, 1'b0, 8);
        check("t2_pending", q_a.size(), 0);

        // T3 long press with auto-repeat
        k = cyc + 1;
        expect_ev(0, c_k_long, k + 8);
        expect_ev(0, c_k_repeat, k + 11);
        expect_ev(0, c_k_repeat, k + 14);
        expect_ev(0, c_k_repeat, k + 17);
        drive(0, 1'b1, 19);
        check("t3_hold", int'(st_a), 4);
        drive(0, 1'b0, 1);
        check("t3_release_idle", int'(st_a), 0);
        drive(0, 1'b0, 6);
        check("t3_pending", q_a.size(), 0);

        // T4a fall coincides with long-press expiry
        k = cyc + 1;
        expect_ev(0, c_k_short, k + 12);
        drive(0, 1'b1, 8);
        drive(0, 1'b0, 1);
        check("t4a_gap", int'(st_a), 2);
        drive(0, 1'b0, 9);
        check("t4a_pending", q_a.size(), 0);

        // T4b rise coincides with gap expiry
        k = cyc + 1;
        expect_ev(0, c_k_double, k + 8);
        drive(0, 1'b1, 2);
        drive(0, 1'b0, 4);
        check("t4b_gap", int'(st_a), 2);
        drive(0, 1'b1, 2);
        check("t4b_press2", int'(st_a), 3);
        drive(0, 1'b0, 8);
        check("t4b_pending", q_a.size(), 0);

        // T5 reset while in GAP, button held through reset release
        drive(0, 1'b1, 2);
        drive(0, 1'b0, 2);
        check("t5_gap", int'(st_a), 2);
        rst_n = 1'b0;
        btn_a = 1'b1;
        @(negedge clk);
        check("t5_rst_state", int'(st_a), 0);
        check("t5_rst_pulses", int'({rp_a, lp_a, dp_a, sp_a}), 0);
        rst_n = 1'b1;
        drive(0, 1'b1, 6);
        check("t5_held_idle", int'(st_a), 0);
        drive(0, 1'b0, 3);
        check("t5_release_idle", int'(st_a), 0);
        k = cyc + 1;
        expect_ev(0, c_k_short, k + 7);
        drive(0, 1'b1, 3);
        drive(0, 1'b0, 10);
        check("t5_pending", q_a.size(), 0);

        // T6 repeat disabled
        k = cyc + 1;
        expect_ev(1, c_k_long, k + 8);
        drive(1, 1'b1, 30);
        check("t6_hold", int'(st_b), 4);
        drive(1, 1'b0, 5);
        check("t6_idle", int'(st_b), 0);
        check("t6_pending", q_b.size(), 0);
        check("final_pending_a", q_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
